// File: rtl/skid_buffer_pkg.sv
// Shared types for the two-entry skid buffer.
// State encoding and occupancy codes.
package skid_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } skid_state_t;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_BUSY  = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

endpackage

// File: rtl/skid_buffer_sync_rst_if.sv
// Valid/ready stream bundle.
// Master drives valid/data; slave drives ready.
interface skid_buffer_sync_rst_if #(
  parameter int WIDTH = 1
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/register_en_sync_rst.sv
// Load-enable register with synchronous
// active-high clear to zero.
module register_en_sync_rst #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skid_buffer_sync_rst.sv
// Two-entry valid/ready skid buffer.
// Every output is taken straight from a flop.
module skid_buffer_sync_rst
  import skid_buffer_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  skid_buffer_sync_rst_if.slave   s,
  skid_buffer_sync_rst_if.master  m,
  output logic [1:0]              count
);

  skid_state_t      state;
  logic             mv_q;
  logic             sr_q;
  logic             s_fire;
  logic             m_fire;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign s_fire  = s.valid & sr_q;
  assign m_fire  = mv_q & m.ready;
  assign s.ready = sr_q;
  assign m.valid = mv_q;
  assign m.data  = main_q;

  // On a FULL drain the skid word moves up into main.
  always_comb begin
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = s.data;
    unique case (state)
      EMPTY: main_en = s_fire;
      BUSY: begin
        main_en = s_fire & m_fire;
        skid_en = s_fire & ~m_fire;
      end
      FULL: begin
        main_en = m_fire;
        main_d  = skid_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      mv_q  <= 1'b0;
      sr_q  <= 1'b1;
      count <= CNT_EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (s_fire) begin
            state <= BUSY;
            mv_q  <= 1'b1;
            count <= CNT_BUSY;
          end
        end
        BUSY: begin
          if (s_fire & ~m_fire) begin
            state <= FULL;
            sr_q  <= 1'b0;
            count <= CNT_FULL;
          end else if (~s_fire & m_fire) begin
            state <= EMPTY;
            mv_q  <= 1'b0;
            count <= CNT_EMPTY;
          end
        end
        FULL: begin
          if (m_fire) begin
            state <= BUSY;
            sr_q  <= 1'b1;
            count <= CNT_BUSY;
          end
        end
        default: begin
          state <= EMPTY;
          mv_q  <= 1'b0;
          sr_q  <= 1'b1;
          count <= CNT_EMPTY;
        end
      endcase
    end
  end

  register_en_sync_rst #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  register_en_sync_rst #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (s.data),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_skid_buffer_sync_rst.sv
// Directed and random checks for the
// two-entry skid buffer.
module tb_skid_buffer_sync_rst;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] count;
  int         checks   = 0;
  int         failures = 0;

  skid_buffer_sync_rst_if #(.WIDTH(W)) s_if ();
  skid_buffer_sync_rst_if #(.WIDTH(W)) m_if ();

  skid_buffer_sync_rst #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .s     (s_if),
    .m     (m_if),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drain();
    s_if.valid = 1'b0;
    m_if.ready = 1'b1;
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_if.valid = 1'b1;
    s_if.data  = 8'hA5;
    m_if.ready = 1'b0;
    step();
    step();
    chk("rst_m_valid", 32'(m_if.valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_m_data", 32'(m_if.data), 32'h00);
    chk("rst_s_ready", 32'(s_if.ready), 32'd1);
    rst = 1'b0;
    s_if.valid = 1'b0;
    step();
    chk("rst_idle_m_valid", 32'(m_if.valid), 32'd0);
  endtask

  task automatic test_streaming();
    m_if.ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 8'(i);
      chk("stream_s_ready", 32'(s_if.ready), 32'd1);
      step();
      chk("stream_m_valid", 32'(m_if.valid), 32'd1);
      chk("stream_m_data", 32'(m_if.data), 32'(i));
      chk("stream_count", 32'(count), 32'd1);
    end
    s_if.valid = 1'b0;
    step();
    chk("stream_end_valid", 32'(m_if.valid), 32'd0);
    chk("stream_end_count", 32'(count), 32'd0);
  endtask

  task automatic test_backpressure();
    m_if.ready = 1'b0;
    s_if.valid = 1'b1;
    s_if.data  = 8'h11;
    step();
    chk("bp1_count", 32'(count), 32'd1);
    chk("bp1_data", 32'(m_if.data), 32'h11);
    chk("bp1_s_ready", 32'(s_if.ready), 32'd1);
    s_if.data = 8'h22;
    step();
    chk("bp2_count", 32'(count), 32'd2);
    chk("bp2_s_ready", 32'(s_if.ready), 32'd0);
    chk("bp2_data", 32'(m_if.data), 32'h11);
    s_if.data = 8'h33;
    step();
    chk("bp3_count", 32'(count), 32'd2);
    chk("bp3_stable", 32'(m_if.data), 32'h11);
    chk("bp3_valid", 32'(m_if.valid), 32'd1);
    m_if.ready = 1'b1;
    step();
    chk("bp4_data", 32'(m_if.data), 32'h22);
    chk("bp4_count", 32'(count), 32'd1);
    chk("bp4_s_ready", 32'(s_if.ready), 32'd1);
    step();
    chk("bp5_data", 32'(m_if.data), 32'h33);
    chk("bp5_count", 32'(count), 32'd1);
    s_if.valid = 1'b0;
    step();
    chk("bp6_valid", 32'(m_if.valid), 32'd0);
    chk("bp6_count", 32'(count), 32'd0);
  endtask

  task automatic test_back_to_back();
    s_if.valid = 1'b1;
    m_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_if.data = 8'h40 + 8'(i);
      step();
      chk("b2b_count", 32'(count), 32'd1);
      chk("b2b_s_ready", 32'(s_if.ready), 32'd1);
      chk("b2b_data", 32'(m_if.data), 32'h40 + 32'(i));
    end
    drain();
  endtask

  task automatic test_reset_full();
    m_if.ready = 1'b0;
    s_if.valid = 1'b1;
    s_if.data  = 8'h77;
    step();
    s_if.data = 8'h88;
    step();
    chk("rf_fill_count", 32'(count), 32'd2);
    rst = 1'b1;
    s_if.valid = 1'b0;
    step();
    rst = 1'b0;
    chk("rf_count", 32'(count), 32'd0);
    chk("rf_m_valid", 32'(m_if.valid), 32'd0);
    chk("rf_s_ready", 32'(s_if.ready), 32'd1);
    chk("rf_m_data", 32'(m_if.data), 32'h00);
    m_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rf_no_emit", 32'(m_if.valid), 32'd0);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic         sf, mf;
    logic         stalled = 1'b0;
    logic [W-1:0] held = '0;
    for (int c = 0; c < 10000; c++) begin
      s_if.valid = 1'($urandom_range(0, 1));
      m_if.ready = 1'($urandom_range(0, 1));
      s_if.data  = 8'($urandom);
      chk("rnd_count", 32'(count), 32'(q.size()));
      chk("rnd_m_valid", 32'(m_if.valid), 32'(q.size() != 0));
      chk("rnd_s_ready", 32'(s_if.ready), 32'(q.size() < 2));
      if (q.size() != 0)
        chk("rnd_order", 32'(m_if.data), 32'(q[0]));
      if (stalled)
        chk("rnd_stable", 32'(m_if.data), 32'(held));
      sf = s_if.valid && (q.size() < 2);
      mf = m_if.ready && (q.size() != 0);
      stalled = (q.size() != 0) && !m_if.ready;
      held = m_if.data;
      step();
      if (mf) void'(q.pop_front());
      if (sf) q.push_back(s_if.data);
    end
    drain();
  endtask

  initial begin
    rst = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    m_if.ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_reset_full();
    drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
